wb_csr_seq: RTL and testbench
=============================

WB_CSR_SEQ -- requirements
Module: wb_csr_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width; CSR_AW, default 12, CSR address width; RAW, default 5, GPR address width; ILEN, default 32, instruction width.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: wb_valid_i  in  1  MEM/WB entry present; flush_i  in  1  discard presented entry; stall_o  out  1  upstream MEM/WB register hold request.
REQ-004 SHALL have ports: pc_i  in  XLEN; inst_i  in  ILEN; rd_addr_i  in  RAW; mem_data_i  in  XLEN  GPR writeback data.
REQ-005 SHALL have ports: csr_valid_i  in  1; csr_addr_i  in  CSR_AW; csr_data_i  in  XLEN  generic CSR write.
REQ-006 SHALL have ports: {mstatus,mepc,mcause,mtval,mtvec}_wvalid_i  in  1 each; {mstatus,mepc,mcause,mtval,mtvec}_wdata_i  in  XLEN each  trap CSR writes.
REQ-007 SHALL have ports: gpr_wen_o  out  1; gpr_waddr_o  out  RAW; gpr_wdata_o  out  XLEN  single GPR write port.
REQ-008 SHALL have ports: csr_wen_o  out  1; csr_waddr_o  out  CSR_AW; csr_wdata_o  out  XLEN  single CSR write port.
REQ-009 SHALL have ports: commit_valid_o  out  1; commit_pc_o  out  XLEN; commit_inst_o  out  ILEN; commit_cnt_o  out  64  retired-entry counter.

Function
REQ-010 Capture SHALL occur on a rising clk edge when wb_valid_i=1, flush_i=0, stall_o=0; all inputs are latched, including a 6-bit pending mask: bit0 generic CSR, bit1 mstatus, bit2 mepc, bit3 mcause, bit4 mtval, bit5 mtvec.
REQ-011 Inputs presented while stall_o=1 or flush_i=1 SHALL be ignored; flush_i SHALL NOT cancel already captured writes.
REQ-012 FSM SHALL have states IDLE and ISSUE; capture moves to ISSUE; ISSUE with pending mask becoming empty and no capture returns to IDLE.
REQ-013 The cycle after capture (first ISSUE cycle) SHALL assert gpr_wen_o=1 iff rd_addr!=0, with latched addr/data, for exactly one cycle.
REQ-014 Each ISSUE cycle SHALL issue exactly one CSR write, the lowest set pending bit, on csr_*_o; that bit clears at cycle end; trap CSR addresses come from package constants.
REQ-015 stall_o SHALL equal (popcount(pending)>=2), from registered state only; an entry with k>=2 CSR writes stalls upstream k-1 cycles.
REQ-016 A new capture SHALL be allowed in the cycle the final pending write issues, giving back-to-back issue without bubbles.
REQ-017 commit_valid_o SHALL pulse one cycle with latched pc/inst in the cycle the entry's final write issues, or in the first ISSUE cycle if mask is zero.
REQ-018 commit_cnt_o SHALL increment by 1 per commit_valid_o pulse, wrapping modulo 2^64.
REQ-019 When idle, csr_wen_o, gpr_wen_o, commit_valid_o SHALL be 0; address/data outputs hold last value.

Reset
REQ-020 rst low SHALL asynchronously force IDLE, pending=0, stall_o=0, all wen/valid outputs 0, all data/address outputs 0, commit_cnt_o=0, commit_inst_o=NOP (0x00000013).
REQ-021 Reset mid-sequence SHALL drop remaining pending writes without issuing them.

Structure
REQ-022 Trap CSR addresses (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343), mask bit indices and NOP SHALL reside in the shared sysconfig package.
REQ-023 A priority-encoder sub-module pick_lowest6 (mask -> index, one-hot) SHALL select the issuing write.

Verification
REQ-024 Entry rd=5, data 0xAB, no CSR -> next cycle gpr_wen_o=1 addr 5, commit_valid_o=1, stall_o never 1.
REQ-025 Trap entry mepc=0x8000_0010, mcause=2, mstatus=0x1800 -> writes 0x300, 0x341, 0x342 on three consecutive cycles; stall_o high 2 cycles; commit_valid_o on third.
REQ-026 rd=0 with csr_valid_i addr 0x340 -> gpr_wen_o stays 0; single CSR write 0x340; commit_cnt_o +1.
REQ-027 Entry with flush_i=1 -> no writes, no commit; held entry during stall_o=1 captured once only.
REQ-028 rst low during second of four trap writes -> all outputs 0 immediately; no further writes after release.

Source files
------------

// File: rtl/wb_csr_seq_pkg.sv
`default_nettype none
//==============================================================================
// wb_csr_seq_pkg : shared sysconfig constants (trap CSR map, mask bits, NOP)
// Revision 1.0
//==============================================================================
package wb_csr_seq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned PB_GEN     = 0;
  localparam int unsigned PB_MSTATUS = 1;
  localparam int unsigned PB_MEPC    = 2;
  localparam int unsigned PB_MCAUSE  = 3;
  localparam int unsigned PB_MTVAL   = 4;
  localparam int unsigned PB_MTVEC   = 5;
  localparam int unsigned NUM_PB     = 6;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_t;

  function automatic logic [2:0] popcount6(input logic [5:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 6; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_csr_seq_pick_lowest6.sv
`default_nettype none
//==============================================================================
// pick_lowest6 : lowest-set-bit priority encoder for the pending write mask
// Revision 1.0
//==============================================================================
module pick_lowest6 (
  input  logic [5:0] i_mask,
  output logic [2:0] o_idx,
  output logic [5:0] o_onehot,
  output logic       o_valid
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    o_idx    = 3'd0;
    o_onehot = 6'd0;
    for (int i = 5; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx    = 3'(i);
        o_onehot = 6'd1 << i;
      end
    end
    o_valid = |i_mask;
  end

endmodule
`default_nettype wire

// File: rtl/wb_csr_seq.sv
`default_nettype none
//==============================================================================
// wb_csr_seq : sequences one MEM/WB entry into single GPR and CSR write ports
// Revision 1.0
//==============================================================================
module wb_csr_seq
  import wb_csr_seq_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12,
  parameter int RAW    = 5,
  parameter int ILEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid_i,
  input  logic              flush_i,
  output logic              stall_o,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [ILEN-1:0]   inst_i,
  input  logic [RAW-1:0]    rd_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              csr_valid_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   csr_data_i,
  input  logic              mstatus_wvalid_i,
  input  logic              mepc_wvalid_i,
  input  logic              mcause_wvalid_i,
  input  logic              mtval_wvalid_i,
  input  logic              mtvec_wvalid_i,
  input  logic [XLEN-1:0]   mstatus_wdata_i,
  input  logic [XLEN-1:0]   mepc_wdata_i,
  input  logic [XLEN-1:0]   mcause_wdata_i,
  input  logic [XLEN-1:0]   mtval_wdata_i,
  input  logic [XLEN-1:0]   mtvec_wdata_i,
  output logic              gpr_wen_o,
  output logic [RAW-1:0]    gpr_waddr_o,
  output logic [XLEN-1:0]   gpr_wdata_o,
  output logic              csr_wen_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              commit_valid_o,
  output logic [XLEN-1:0]   commit_pc_o,
  output logic [ILEN-1:0]   commit_inst_o,
  output logic [63:0]       commit_cnt_o
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [5:0]        r_pend;
  logic [5:0]        w_pend_nxt;
  logic              r_first;

  logic [XLEN-1:0]   r_pc;
  logic [ILEN-1:0]   r_inst;
  logic [RAW-1:0]    r_rd;
  logic [XLEN-1:0]   r_mem;
  logic [CSR_AW-1:0] r_gen_addr;
  logic [XLEN-1:0]   r_csr_dat [NUM_PB];
  logic [CSR_AW-1:0] r_csr_waddr;
  logic [XLEN-1:0]   r_csr_wdata;
  logic [63:0]       r_cnt;

  logic [5:0]        w_mask_in;
  logic [CSR_AW-1:0] w_addr_tab [NUM_PB];
  logic [2:0]        w_idx;
  logic [5:0]        w_onehot;
  logic              w_any;
  logic [2:0]        w_pend_cnt;
  logic              w_in_issue;
  logic              w_issue;
  logic              w_commit;
  logic              w_capture;

  pick_lowest6 u_pick (
    .i_mask   (r_pend),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_valid  (w_any)
  );

  assign w_pend_cnt = popcount6(r_pend);
  assign stall_o    = (w_pend_cnt >= 3'd2);
  assign w_capture  = wb_valid_i & ~flush_i & ~stall_o;
  assign w_in_issue = (r_state == ST_ISSUE);
  assign w_issue    = w_in_issue & w_any;
  // The entry retires on its last CSR write, or immediately when it has none.
  assign w_commit   = w_in_issue & (w_pend_cnt <= 3'd1);

  always_comb begin
    w_mask_in             = 6'd0;
    w_mask_in[PB_GEN]     = csr_valid_i;
    w_mask_in[PB_MSTATUS] = mstatus_wvalid_i;
    w_mask_in[PB_MEPC]    = mepc_wvalid_i;
    w_mask_in[PB_MCAUSE]  = mcause_wvalid_i;
    w_mask_in[PB_MTVAL]   = mtval_wvalid_i;
    w_mask_in[PB_MTVEC]   = mtvec_wvalid_i;

    w_addr_tab[PB_GEN]     = r_gen_addr;
    w_addr_tab[PB_MSTATUS] = CSR_AW'(CSR_MSTATUS);
    w_addr_tab[PB_MEPC]    = CSR_AW'(CSR_MEPC);
    w_addr_tab[PB_MCAUSE]  = CSR_AW'(CSR_MCAUSE);
    w_addr_tab[PB_MTVAL]   = CSR_AW'(CSR_MTVAL);
    w_addr_tab[PB_MTVEC]   = CSR_AW'(CSR_MTVEC);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_pend;
    gpr_wen_o      = 1'b0;
    csr_wen_o      = 1'b0;
    csr_waddr_o    = r_csr_waddr;
    csr_wdata_o    = r_csr_wdata;
    commit_valid_o = 1'b0;

    if (w_in_issue) begin
      w_pend_nxt     = r_pend & ~w_onehot;
      gpr_wen_o      = r_first & (r_rd != '0);
      commit_valid_o = w_commit;
      if (w_any) begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = w_addr_tab[w_idx];
        csr_wdata_o = r_csr_dat[w_idx];
      end
    end

    // A capture may land in the same cycle the previous entry's last write issues.
    if (w_capture) begin
      w_state_nxt = ST_ISSUE;
      w_pend_nxt  = w_mask_in;
    end else if (w_in_issue && (w_pend_nxt == 6'd0)) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pend  <= 6'd0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_first <= w_capture;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= '0;
      r_inst      <= ILEN'(INST_NOP);
      r_rd        <= '0;
      r_mem       <= '0;
      r_gen_addr  <= '0;
      for (int i = 0; i < NUM_PB; i++) begin
        r_csr_dat[i] <= '0;
      end
      r_csr_waddr <= '0;
      r_csr_wdata <= '0;
      r_cnt       <= 64'd0;
    end else begin
      if (w_capture) begin
        r_pc                  <= pc_i;
        r_inst                <= inst_i;
        r_rd                  <= rd_addr_i;
        r_mem                 <= mem_data_i;
        r_gen_addr            <= csr_addr_i;
        r_csr_dat[PB_GEN]     <= csr_data_i;
        r_csr_dat[PB_MSTATUS] <= mstatus_wdata_i;
        r_csr_dat[PB_MEPC]    <= mepc_wdata_i;
        r_csr_dat[PB_MCAUSE]  <= mcause_wdata_i;
        r_csr_dat[PB_MTVAL]   <= mtval_wdata_i;
        r_csr_dat[PB_MTVEC]   <= mtvec_wdata_i;
      end
      if (w_issue) begin
        r_csr_waddr <= csr_waddr_o;
        r_csr_wdata <= csr_wdata_o;
      end
      if (w_commit) begin
        r_cnt <= r_cnt + 64'd1;
      end
    end
  end

  assign gpr_waddr_o   = r_rd;
  assign gpr_wdata_o   = r_mem;
  assign commit_pc_o   = r_pc;
  assign commit_inst_o = r_inst;
  assign commit_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_csr_seq.sv
`default_nettype none
//==============================================================================
// tb_wb_csr_seq : randomized scoreboard bench for wb_csr_seq
// Revision 1.0
//==============================================================================
module tb_wb_csr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid_i = 1'b0, flush_i = 1'b0;
  logic [63:0] pc_i = '0, mem_data_i = '0, csr_data_i = '0;
  logic [31:0] inst_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        csr_valid_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic        mstatus_wvalid_i = 1'b0, mepc_wvalid_i = 1'b0, mcause_wvalid_i = 1'b0;
  logic        mtval_wvalid_i = 1'b0, mtvec_wvalid_i = 1'b0;
  logic [63:0] mstatus_wdata_i = '0, mepc_wdata_i = '0, mcause_wdata_i = '0;
  logic [63:0] mtval_wdata_i = '0, mtvec_wdata_i = '0;
  wire         stall_o, gpr_wen_o, csr_wen_o, commit_valid_o;
  wire  [4:0]  gpr_waddr_o;
  wire  [63:0] gpr_wdata_o, csr_wdata_o, commit_pc_o, commit_cnt_o;
  wire  [11:0] csr_waddr_o;
  wire  [31:0] commit_inst_o;

  always #5 clk = ~clk;

  wb_csr_seq dut (
    .clk(clk), .rst(rst), .wb_valid_i(wb_valid_i), .flush_i(flush_i), .stall_o(stall_o),
    .pc_i(pc_i), .inst_i(inst_i), .rd_addr_i(rd_addr_i), .mem_data_i(mem_data_i),
    .csr_valid_i(csr_valid_i), .csr_addr_i(csr_addr_i), .csr_data_i(csr_data_i),
    .mstatus_wvalid_i(mstatus_wvalid_i), .mepc_wvalid_i(mepc_wvalid_i),
    .mcause_wvalid_i(mcause_wvalid_i), .mtval_wvalid_i(mtval_wvalid_i),
    .mtvec_wvalid_i(mtvec_wvalid_i), .mstatus_wdata_i(mstatus_wdata_i),
    .mepc_wdata_i(mepc_wdata_i), .mcause_wdata_i(mcause_wdata_i),
    .mtval_wdata_i(mtval_wdata_i), .mtvec_wdata_i(mtvec_wdata_i),
    .gpr_wen_o(gpr_wen_o), .gpr_waddr_o(gpr_waddr_o), .gpr_wdata_o(gpr_wdata_o),
    .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
    .commit_inst_o(commit_inst_o), .commit_cnt_o(commit_cnt_o)
  );

  typedef struct packed {
    logic [63:0]       pc;
    logic [31:0]       inst;
    logic [4:0]        rd;
    logic [63:0]       mem;
    logic [5:0]        mask;
    logic [11:0]       ga;
    logic [5:0][63:0]  d;
  } entry_t;
  typedef struct packed { logic [31:0] win; logic [4:0]  a;  logic [63:0] d;    } gev_t;
  typedef struct packed { logic [31:0] win; logic [11:0] a;  logic [63:0] d;    } cev_t;
  typedef struct packed { logic [31:0] win; logic [63:0] pc; logic [31:0] inst; } mev_t;

  gev_t        gq[$];
  cev_t        cq[$];
  mev_t        mq[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned last_c0 = 0;
  int unsigned last_k = 0;
  logic [63:0] m_cnt = '0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Window t is the span after the t-th rising edge; an entry accepted in window c
  // with k CSR writes occupies windows c+1..c+k and stalls upstream for k-1 of them.
  function automatic logic m_stall();
    return (last_k >= 2) && (cyc >= last_c0 + 1) && (cyc <= last_c0 + last_k - 1);
  endfunction

  function automatic logic [11:0] exp_addr(input int i, input logic [11:0] ga);
    case (i)
      0: return ga;
      1: return 12'h300;
      2: return 12'h341;
      3: return 12'h342;
      4: return 12'h343;
      default: return 12'h305;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (window %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: window %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      logic due;
      check("stall", {63'd0, stall_o}, {63'd0, m_stall()});
      check("commit_cnt", commit_cnt_o, m_cnt);

      due = (gq.size() > 0) && (gq[0].win == cyc);
      if (gpr_wen_o || due) begin
        if (!due) flag("gpr_unexpected");
        else begin
          if (!gpr_wen_o) flag("gpr_missing");
          else begin
            check("gpr_addr", {59'd0, gpr_waddr_o}, {59'd0, gq[0].a});
            check("gpr_data", gpr_wdata_o, gq[0].d);
          end
          void'(gq.pop_front());
        end
      end

      due = (cq.size() > 0) && (cq[0].win == cyc);
      if (csr_wen_o || due) begin
        if (!due) flag("csr_unexpected");
        else begin
          if (!csr_wen_o) flag("csr_missing");
          else begin
            check("csr_addr", {52'd0, csr_waddr_o}, {52'd0, cq[0].a});
            check("csr_data", csr_wdata_o, cq[0].d);
          end
          void'(cq.pop_front());
        end
      end

      due = (mq.size() > 0) && (mq[0].win == cyc);
      if (commit_valid_o || due) begin
        if (!due) flag("commit_unexpected");
        else begin
          if (!commit_valid_o) flag("commit_missing");
          else begin
            check("commit_pc", commit_pc_o, mq[0].pc);
            check("commit_inst", {32'd0, commit_inst_o}, {32'd0, mq[0].inst});
          end
          void'(mq.pop_front());
          m_cnt = m_cnt + 64'd1;
        end
      end
    end
  end

  task automatic push_expect(input entry_t e);
    int unsigned c, k, w;
    c = cyc;
    k = 0;
    for (int i = 0; i < 6; i++) k += int'(e.mask[i]);
    if (e.rd != 5'd0) gq.push_back('{win: c + 1, a: e.rd, d: e.mem});
    w = c + 1;
    for (int i = 0; i < 6; i++) begin
      if (e.mask[i]) begin
        cq.push_back('{win: w, a: exp_addr(i, e.ga), d: e.d[i]});
        w++;
      end
    end
    mq.push_back('{win: c + ((k == 0) ? 1 : k), pc: e.pc, inst: e.inst});
    last_c0 = c;
    last_k  = k;
  endtask

  task automatic drive(input entry_t e, input bit v, input bit fl, output bit acc);
    @(negedge clk);
    wb_valid_i = v;          flush_i = fl;
    pc_i = e.pc;             inst_i = e.inst;
    rd_addr_i = e.rd;        mem_data_i = e.mem;
    csr_valid_i = e.mask[0]; csr_addr_i = e.ga;  csr_data_i = e.d[0];
    mstatus_wvalid_i = e.mask[1]; mstatus_wdata_i = e.d[1];
    mepc_wvalid_i    = e.mask[2]; mepc_wdata_i    = e.d[2];
    mcause_wvalid_i  = e.mask[3]; mcause_wdata_i  = e.d[3];
    mtval_wvalid_i   = e.mask[4]; mtval_wdata_i   = e.d[4];
    mtvec_wvalid_i   = e.mask[5]; mtvec_wdata_i   = e.d[5];
    acc = v && !fl && !m_stall();
    if (acc) push_expect(e);
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    e.pc   = {$urandom, $urandom};
    e.inst = $urandom;
    e.rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    e.mem  = {$urandom, $urandom};
    e.mask = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
    e.ga   = 12'($urandom);
    for (int i = 0; i < 6; i++) e.d[i] = {$urandom, $urandom};
    return e;
  endfunction

  task automatic hold(input entry_t e);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) drive(e, 1'b1, 1'b0, acc);
    if (!acc) flag("hold_timeout");
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) drive(rand_entry(), 1'b0, 1'b0, acc);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_gpr_wen"}, {63'd0, gpr_wen_o}, 64'd0);
    check({tag, "_csr_wen"}, {63'd0, csr_wen_o}, 64'd0);
    check({tag, "_commit_valid"}, {63'd0, commit_valid_o}, 64'd0);
    check({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
    check({tag, "_gpr_addr_data"}, gpr_wdata_o | {59'd0, gpr_waddr_o}, 64'd0);
    check({tag, "_csr_addr_data"}, csr_wdata_o | {52'd0, csr_waddr_o}, 64'd0);
    check({tag, "_commit_pc"}, commit_pc_o, 64'd0);
    check({tag, "_commit_cnt"}, commit_cnt_o, 64'd0);
    check({tag, "_commit_inst"}, {32'd0, commit_inst_o}, 64'h13);
  endtask

  initial begin
    entry_t e;
    bit acc;

    repeat (3) @(negedge clk);
    check_all_reset("reset");
    rst    = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // GPR-only entry.
    e = '0; e.pc = 64'h1000; e.inst = 32'h0050_0293; e.rd = 5'd5; e.mem = 64'hAB;
    hold(e);
    idle(3);

    // Trap entry: mstatus, mepc, mcause.
    e = '0; e.pc = 64'h8000_0000; e.inst = 32'h0000_0073; e.rd = 5'd0;
    e.mask = 6'b001110; e.d[1] = 64'h1800; e.d[2] = 64'h8000_0010; e.d[3] = 64'd2;
    hold(e);
    idle(5);

    // Generic CSR write, rd=0.
    e = '0; e.pc = 64'h2000; e.inst = 32'h3400_1073; e.mask = 6'b000001;
    e.ga = 12'h340; e.d[0] = 64'hDEAD_BEEF;
    hold(e);
    idle(3);

    // Flushed entry leaves no trace.
    e = rand_entry(); e.rd = 5'd7; e.mask = 6'b100001;
    drive(e, 1'b1, 1'b1, acc);
    idle(3);

    // Entry held while upstream is stalled is captured exactly once.
    e = rand_entry(); e.mask = 6'b011100;
    hold(e);
    e = rand_entry(); e.rd = 5'd9; e.mask = 6'b000010;
    hold(e);
    idle(6);

    // Back-to-back single-write entries.
    for (int i = 0; i < 6; i++) begin
      e = rand_entry(); e.mask = 6'd1 << i;
      hold(e);
    end
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      e = rand_entry();
      drive(e, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), acc);
    end
    idle(8);

    // Asynchronous reset during the second of four trap writes.
    e = rand_entry(); e.rd = 5'd3; e.mask = 6'b011110;
    hold(e);
    idle(2);
    #2;
    rst = 1'b0;
    #1;
    check_all_reset("midreset");
    gq.delete(); cq.delete(); mq.delete();
    m_cnt   = '0;
    last_k  = 0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle(8);
    check("post_reset_cnt", commit_cnt_o, 64'd0);

    check("queues_empty", 64'(gq.size() + cq.size() + mq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
